// File: rtl/ram_ctrl.sv
// ram_ctrl: parametrised TRSQ8 data RAM with a post-reset clearing sweep,
// pipelined reads, an optional status-word mirror and a write-protected window.
module ram_ctrl #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                DEPTH      = 128,
  parameter int                RD_LATENCY = 1,
  parameter int                STATUS_EN  = 1,
  parameter int                WP_LO      = 0,
  parameter int                WP_HI      = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] cpu_status,
  output logic              ready,
  output logic              rd_valid,
  output logic              wr_err
);

  localparam int                OFF_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                MASK_N    = 1 << OFF_W;
  localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  init_ptr_q, init_ptr_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_v1_q, rd_v1_d;
  logic              sel_status_q, sel_status_d;

  logic [ADDR_W-1:0] rel_addr;
  logic              hit;
  logic [OFF_W-1:0]  offset;

  logic              mem_we;
  logic [OFF_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_acc;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd_q;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;

  // Addresses below BASE_ADDR wrap to a large offset, so one compare covers both bounds.
  assign rel_addr = addr - BASE_ADDR;
  assign hit      = ({1'b0, rel_addr} < DEPTH_EXT);
  assign offset   = rel_addr[OFF_W-1:0];

  logic [MASK_N-1:0] prot_mask;
  for (genvar gi = 0; gi < MASK_N; gi++) begin : g_prot
    assign prot_mask[gi] = ((gi >= WP_LO) && (gi <= WP_HI)) ||
                           ((STATUS_EN != 0) && (gi == 0));
  end

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    wr_err_d     = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = offset;
    mem_wdata    = dout;
    rd_acc       = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Held-in-reset must leave memory alone; the sweep starts on release.
        mem_we     = reset_n;
        mem_waddr  = init_ptr_q;
        mem_wdata  = '0;
        init_ptr_d = init_ptr_q + OFF_W'(1);
        if (init_ptr_q == LAST_OFF) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        rd_acc = rd_en & hit;
        if (wr_en && hit) begin
          if (prot_mask[offset]) wr_err_d = 1'b1;
          else                   mem_we   = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    rd_v1_d      = rd_acc;
    sel_status_d = rd_acc && (STATUS_EN != 0) && (offset == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      wr_err_q     <= 1'b0;
      rd_v1_q      <= 1'b0;
      sel_status_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      wr_err_q     <= wr_err_d;
      rd_v1_q      <= rd_v1_d;
      sel_status_q <= sel_status_d;
    end
  end

  // Single-port style array: the read sees the pre-write word on a same-edge hit.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_acc) mem_rd_q <= mem[offset];
  end

  if (STATUS_EN != 0) begin : g_status
    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] status_rd_q;

    assign status_d = (state_q == ST_IDLE) ? cpu_status : status_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) status_q <= '0;
      else          status_q <= status_d;
    end

    // Snapshot of the word as it stood at the accept edge.
    always_ff @(posedge clk) begin
      if (rd_acc) status_rd_q <= status_q;
    end

    assign rd_word = sel_status_q ? status_rd_q : mem_rd_q;
  end else begin : g_no_status
    assign rd_word = mem_rd_q;
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              rd_v2_q;
    logic [DATA_W-1:0] rd_d2_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_v2_q <= 1'b0;
        rd_d2_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        rd_d2_q <= rd_word;
      end
    end

    assign rd_valid = rd_v2_q;
    assign rd_data  = rd_d2_q;
  end else begin : g_lat1
    assign rd_valid = rd_v1_q;
    assign rd_data  = rd_word;
  end

  assign din    = rd_valid ? rd_data : {DATA_W{1'bz}};
  assign ready  = (state_q == ST_IDLE);
  assign wr_err = wr_err_q;

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised memory-mapped data RAM for the TRSQ8 CPU data bus.
- Generalises the 8-bit/128-word RAM: configurable data width, depth and base address; registered read with 1- or 2-cycle latency and a valid strobe; status-word mirror; write-protected window with error pulse.
- Memory clearing is a sequential post-reset INIT sweep (BRAM-friendly) rather than a parallel reset.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 8, CPU address width.
- BASE_ADDR, 8'h00, first mapped CPU address.
- DEPTH, 128, words mapped; BASE_ADDR+DEPTH-1 must fit in ADDR_W.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- STATUS_EN, 1, 1 = offset 0 is a read-only mirror of cpu_status.
- WP_LO, 0, first write-protected offset.
- WP_HI, 0, last write-protected offset; WP_HI < WP_LO disables protection.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  CPU address.
- dout  in  DATA_W  CPU write data.
- din  out  DATA_W  read data to CPU; high-Z unless rd_valid=1.
- wr_en  in  1  CPU write strobe.
- rd_en  in  1  CPU read strobe.
- cpu_status  in  DATA_W  status value mirrored at offset 0.
- ready  out  1  1 = accesses accepted; 0 during INIT.
- rd_valid  out  1  one-cycle pulse marking read data on din.
- wr_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Address decode:
  - hit = (addr >= BASE_ADDR) && (addr <= BASE_ADDR+DEPTH-1).
  - offset = addr - BASE_ADDR, width clog2(DEPTH).
  - Miss: no memory effect, no rd_valid, no wr_err, din stays high-Z.
- Reset (async assert, any state, including mid-INIT or mid-read):
  - State goes to INIT with init_ptr=0.
  - ready=0, rd_valid=0, wr_err=0, din high-Z, read pipeline flushed.
  - Memory contents are not touched by reset itself.
- INIT state:
  - Each cycle writes 0 to mem[init_ptr], then increments init_ptr.
  - After writing offset DEPTH-1, go to IDLE; ready=1 from the next cycle. INIT therefore lasts exactly DEPTH cycles after reset release.
  - CPU wr_en/rd_en during INIT are ignored: no memory effect, no rd_valid, no wr_err.
- IDLE state: ready=1; a hit with wr_en or rd_en is accepted on the clock edge.
- Write (wr_en & hit & ready):
  - mem[offset] <= dout on that edge.
  - Rejected instead, with wr_err=1 on the next cycle and memory unchanged, if STATUS_EN=1 and offset==0, or if WP_LO <= offset <= WP_HI.
- Status mirror (STATUS_EN=1):
  - Word 0 captures cpu_status on every clock edge in IDLE.
  - A read of offset 0 returns cpu_status as sampled on the edge before the accept edge.
- Read (rd_en & hit & ready):
  - Data is registered; rd_valid=1 and din=data for exactly one cycle, RD_LATENCY cycles after the accept edge.
  - Back-to-back reads are accepted every cycle; results return in order, one per cycle.
- Simultaneous rd_en & wr_en to the same offset: memory takes the new data; the read returns the old data (read-before-write).
- Width: dout and cpu_status are used at full DATA_W; there is no truncation.

Test Plan:
- Release reset, hold rd_en=1 at addr 8'h05 throughout: ready=0 for exactly 128 cycles; no rd_valid during INIT; first read after ready returns 8'h00 with rd_valid 1 cycle later.
- After INIT, write 8'hA5 to 8'h10, then read 8'h10 with RD_LATENCY=1: din=8'hA5 and rd_valid=1 on cycle +1. Repeat with RD_LATENCY=2: response on cycle +2.
- Reads of 8'h10, 8'h11, 8'h12 on consecutive cycles after writing 1, 2, 3: rd_valid high 3 consecutive cycles with din=1,2,3; a read at 8'h80 gives no rd_valid and din=Z.
- cpu_status=8'h3C, then write 8'hFF to 8'h00: wr_err pulses 1 cycle; a read of 8'h00 returns 8'h3C. With WP_LO=4, WP_HI=7, a write to 8'h06 raises wr_err and memory is unchanged.
- Same-cycle rd_en+wr_en at 8'h20 (old 8'h11, new 8'h22): read returns 8'h11; the next read returns 8'h22.
- Assert reset_n=0 mid-INIT and again with a read in flight: outputs go to reset values immediately; no stale rd_valid; INIT restarts and runs the full 128 cycles.
